// File: rtl/alu_exec.sv
// Two-stage valid/ready ALU: AND/OR/ADD/SUB, plus SLT when ALU_SLT_EN is defined; latency 2.
// Backpressure: a stalled S2 holds its outputs; in_ready drops only when both stages are full.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucmd,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_OR  = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_SUB = 4'b0110;
`ifdef ALU_SLT_EN
  localparam logic [3:0] CMD_SLT = 4'b0111;
`endif

  logic             s1_valid;
  logic             s2_valid;
  logic [3:0]       s1_cmd;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_ovf;
  logic             nxt_ill;

  // S1 may refill on the same edge its contents move on, so only a full, stalled pipe blocks input.
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign out_valid = s2_valid;

  assign sum  = s1_a + s1_b;
  assign diff = s1_a - s1_b;

  always_comb begin
    nxt_res = '0;
    nxt_ovf = 1'b0;
    nxt_ill = 1'b0;
    case (s1_cmd)
      CMD_AND: nxt_res = s1_a & s1_b;
      CMD_OR:  nxt_res = s1_a | s1_b;
      CMD_ADD: begin
        nxt_res = sum;
        nxt_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      CMD_SUB: begin
        nxt_res = diff;
        nxt_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
`ifdef ALU_SLT_EN
      CMD_SLT: nxt_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
`endif
      default: nxt_ill = 1'b1;
    endcase
  end

  // Operand registers need no reset: s1_valid gates every use of them.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_cmd <= alucmd;
      s1_a   <= op_a;
      s1_b   <= op_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;

      if (s2_load)        s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;

      if (s2_load) begin
        result  <= nxt_res;
        zero    <= (nxt_res == '0);
        ovf     <= nxt_ovf;
        illegal <= nxt_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected results queued at accept, compared at output transfer.
module tb_alu_exec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alucmd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
  } exp_t;

  exp_t pend[$];
  int   checks;
  int   failures;
  int   out_cnt;
  int   rdy_mode;
  int   n0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu_exec #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alucmd    (alucmd),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint s;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: begin
        s     = sa + sb;
        e.res = s[31:0];
        e.o   = (s > SMAX) || (s < SMIN);
      end
      4'h6: begin
        s     = sa - sb;
        e.res = s[31:0];
        e.o   = (s > SMAX) || (s < SMIN);
      end
`ifdef ALU_SLT_EN
      4'h7: e.res = (sa < sb) ? 32'd1 : 32'd0;
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // out_ready driver: 0 = hold low, 1 = hold high, otherwise random per cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: sample mid-cycle; transfers take effect on the following rising edge.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [31:0] prev_res;
    logic [2:0]  prev_flags;
    prev_stall = 1'b0;
    prev_res   = '0;
    prev_flags = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_result", result, prev_res);
          check_eq("hold_flags", {zero, ovf, illegal}, prev_flags);
        end
        if (out_valid && out_ready) begin
          out_cnt++;
          if (pend.size() == 0) begin
            check_eq("unexpected_out", out_valid, 0);
          end else begin
            e = pend.pop_front();
            check_eq("result", result, e.res);
            check_eq("zero", zero, e.z);
            check_eq("ovf", ovf, e.o);
            check_eq("illegal", illegal, e.il);
          end
        end
        if (in_valid && in_ready) pend.push_back(model(alucmd, op_a, op_b));
        prev_stall = out_valid && !out_ready;
        prev_res   = result;
        prev_flags = {zero, ovf, illegal};
      end
    end
  end

  task automatic set_rdy(input int m);
    rdy_mode = m;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done     = 1'b0;
    alucmd   = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("accept", done, 1);
    if (!done) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && pend.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain", pend.size(), 0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 3));
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] cmds [8];
    logic [3:0] c;
    cmds = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF, 4'h2, 4'h6};
    checks   = 0;
    failures = 0;
    out_cnt  = 0;
    rdy_mode = 1;
    rst      = 1'b1;
    in_valid = 1'b0;
    alucmd   = '0;
    op_a     = '0;
    op_b     = '0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", {zero, ovf, illegal}, 0);
    rst = 1'b1;

    // ADD overflow, with explicit latency check from the first edge after reset release.
    alucmd = 4'h2; op_a = 32'h7FFF_FFFF; op_b = 32'h1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_eq("lat_edge1", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_edge2", out_valid, 1);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back: three outputs on three consecutive cycles.
    n0 = out_cnt;
    send(4'h6, 32'd5, 32'd5);
    send(4'h0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    send(4'h1, 32'h1, 32'h2);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("b2b_count", out_cnt - n0, 3);

    send(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(4'h7, 32'hFFFF_FFFF, 32'h1);
    in_valid = 1'b0;
    drain();

    // Stall: two accepted, the third must be refused until release.
    set_rdy(0);
    send(4'h2, 32'd10, 32'd20);
    send(4'h6, 32'd100, 32'd1);
    alucmd = 4'h1; op_a = 32'hA0; op_b = 32'h0B; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("full_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    set_rdy(1);
    send(4'h1, 32'hA0, 32'h0B);
    in_valid = 1'b0;
    drain();

    // Reset with both stages full: everything in flight is discarded.
    set_rdy(0);
    send(4'h2, 32'd1, 32'd1);
    send(4'h2, 32'd2, 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_result", result, 0);
    pend.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    set_rdy(1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", out_valid, 0);
    send(4'h2, 32'd2, 32'd3);
    in_valid = 1'b0;
    drain();

    // Random traffic with random downstream backpressure.
    set_rdy(2);
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : cmds[$urandom_range(0, 7)];
      send(c, rnd_op(), rnd_op());
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    set_rdy(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
